ddr_app_responder: RTL

Memory-side responder for the DDR3 controller user-application interface (cmd / cmd_en / cmd_ready, wr_data*, rd_data*). It stands in for the DDR3 IP so the CPU Memory stage can be exercised in simulation and early board bring-up. It is backed by on-chip block RAM of one 256-bit word per burst. It obeys the same handshake rules as the DDR3 IP and adds a fixed read latency and a calibration-delay phase.

---
 rtl/ddr_app_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ddr_app_responder.sv
// ddr_app_responder: block-RAM backed stand-in for the DDR3 controller user-application interface.
// Define RESPONDER_BACKPRESSURE_EN to throttle cmd_ready / wr_data_rdy with a free-running LFSR.
`timescale 1ns/1ps
module ddr_app_responder #(
  parameter int ADDR_WIDTH   = 29,
  parameter int DATA_WIDTH   = 256,
  parameter int MASK_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 4,
  parameter int CALIB_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd,
  input  logic                  cmd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_data_rdy,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_data_en,
  input  logic                  wr_data_end,
  input  logic [MASK_WIDTH-1:0] wr_data_mask,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_data_end,
  output logic                  init_calib_complete,
  output logic                  err_cmd
);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam int         CNT_W     = 16;

  typedef enum logic [2:0] {INIT, IDLE, WR_WAIT, RD_LAT, RD_OUT} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [DATA_WIDTH-1:0]   mem [2**DEPTH_LOG2];
  logic                    buf_full;
  logic [DATA_WIDTH-1:0]   buf_data;
  logic [MASK_WIDTH-1:0]   buf_mask;
  logic [DEPTH_LOG2-1:0]   cmd_idx, saved_idx, ram_idx;
  logic                    cmd_gate, wr_gate;
  logic                    cmd_accept, beat_accept;
  logic                    ram_we;
  logic [DATA_WIDTH-1:0]   ram_data;
  logic [MASK_WIDTH-1:0]   ram_mask;
  logic                    buf_load, buf_clear, rd_load, err_set;
  logic                    unused_addr_bits;

  // Word index drops the column-within-burst bits; upper bits alias onto the RAM.
  assign cmd_idx          = addr[DEPTH_LOG2+2:3];
  assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:DEPTH_LOG2+3], addr[2:0]};

`ifdef RESPONDER_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign cmd_gate = (lfsr[1:0] != 2'b00);
  assign wr_gate  = (lfsr[3:2] != 2'b00);
`else
  assign cmd_gate = 1'b1;
  assign wr_gate  = 1'b1;
`endif

  assign init_calib_complete = (state != INIT);
  assign cmd_ready           = (state == IDLE) && cmd_gate;
  assign wr_data_rdy         = init_calib_complete && !buf_full && wr_gate;
  assign rd_data_valid       = (state == RD_OUT);
  assign rd_data_end         = (state == RD_OUT);
  assign cmd_accept          = cmd_en && cmd_ready;
  assign beat_accept         = wr_data_en && wr_data_rdy;
  assign ram_idx             = (state == WR_WAIT) ? saved_idx : cmd_idx;

  // A beat lands in the buffer unless it is written straight through to RAM.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ram_we     = 1'b0;
    ram_data   = buf_data;
    ram_mask   = buf_mask;
    buf_load   = beat_accept;
    buf_clear  = 1'b0;
    rd_load    = 1'b0;
    err_set    = beat_accept && !wr_data_end;
    case (state)
      INIT: begin
        if (cnt == CNT_W'(CALIB_CYCLES - 1)) state_next = IDLE;
        else                                 cnt_next   = cnt + CNT_W'(1);
      end
      IDLE: begin
        if (cmd_accept) begin
          case (cmd)
            CMD_WRITE: begin
              if (buf_full) begin
                ram_we    = 1'b1;
                buf_clear = 1'b1;
              end else if (beat_accept) begin
                ram_we   = 1'b1;
                ram_data = wr_data;
                ram_mask = wr_data_mask;
                buf_load = 1'b0;
              end else begin
                state_next = WR_WAIT;
              end
            end
            CMD_READ: begin
              state_next = RD_LAT;
              cnt_next   = CNT_W'(READ_LATENCY - 1);
            end
            default: err_set = 1'b1;
          endcase
        end
      end
      WR_WAIT: begin
        if (beat_accept) begin
          ram_we     = 1'b1;
          ram_data   = wr_data;
          ram_mask   = wr_data_mask;
          buf_load   = 1'b0;
          state_next = IDLE;
        end
      end
      RD_LAT: begin
        if (cnt == '0) begin
          state_next = RD_OUT;
          rd_load    = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RD_OUT:  state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      buf_full  <= 1'b0;
      buf_data  <= '0;
      buf_mask  <= '0;
      saved_idx <= '0;
      rd_data   <= '0;
      err_cmd   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (buf_load) begin
        buf_full <= 1'b1;
        buf_data <= wr_data;
        buf_mask <= wr_data_mask;
      end else if (buf_clear) begin
        buf_full <= 1'b0;
      end
      if (cmd_accept) saved_idx <= cmd_idx;
      if (rd_load)    rd_data   <= mem[saved_idx];
      if (err_set)    err_cmd   <= 1'b1;
    end
  end

  // RAM contents survive reset; a set mask bit protects its byte.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (!ram_mask[i]) mem[ram_idx][8*i +: 8] <= ram_data[8*i +: 8];
      end
    end
  end

endmodule
